// File: rtl/countdown_if.sv
// Switch/button inputs and countdown status outputs
// shared between the run controller and its user.
interface countdown_if;
  logic        start;
  logic        pause;
  logic [15:0] sw_val;
  logic [15:0] count;
  logic        running;
  logic        paused;
  logic        done;
  logic        tick;

  modport master (
    output start, pause, sw_val,
    input  count, running, paused, done, tick
  );

  modport slave (
    input  start, pause, sw_val,
    output count, running, paused, done, tick
  );
endinterface

// File: rtl/countdown_ctrl.sv
// Countdown run controller: load on start, one decrement
// per interval, pause/resume, restart and timed DONE hold.
module countdown_ctrl #(
  parameter int unsigned ONE_SEC   = 100_000_000,
  parameter int unsigned DONE_HOLD = 3
) (
  input  logic        clk,
  input  logic        rst,
  countdown_if.slave  bus
);
  localparam int unsigned IW = $clog2(ONE_SEC);
  localparam int unsigned HW = $clog2(DONE_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     count_q, count_d;
  logic [IW-1:0]   ivl_q, ivl_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [HW-1:0]   hold_inc;
  logic            start_q, pause_q;
  logic            start_e, pause_e;
  logic            tick_w;

  assign start_e  = bus.start & ~start_q;
  assign pause_e  = bus.pause & ~pause_q;
  assign hold_inc = hold_q + 1'b1;
  assign tick_w   = ((state_q == RUN) || (state_q == DONE))
                  && (ivl_q == IW'(ONE_SEC - 1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ivl_d   = ivl_q;
    hold_d  = hold_q;
    unique case (state_q)
      RUN, DONE: ivl_d = tick_w ? '0 : ivl_q + 1'b1;
      PAUSE:     ivl_d = ivl_q;
      IDLE:      ivl_d = '0;
    endcase
    if (start_e) begin
      ivl_d  = '0;
      hold_d = '0;
      if (bus.sw_val != 16'd0) begin
        state_d = RUN;
        count_d = bus.sw_val;
      end else begin
        state_d = DONE;
        count_d = 16'd0;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (tick_w) begin
            count_d = count_q - 16'd1;
            // reaching zero outranks a coincident pause
            if (count_q == 16'd1) begin
              state_d = DONE;
              hold_d  = '0;
            end else if (pause_e) begin
              state_d = PAUSE;
            end
          end else if (pause_e) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (pause_e) state_d = RUN;
        end
        DONE: begin
          count_d = 16'd0;
          if (tick_w) begin
            hold_d = hold_inc;
            if (hold_inc == HW'(DONE_HOLD)) begin
              state_d = IDLE;
              ivl_d   = '0;
            end
          end
        end
        IDLE: count_d = 16'd0;
      endcase
    end
  end

  // edge flops reset high so a held button is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= 16'd0;
      ivl_q   <= '0;
      hold_q  <= '0;
      start_q <= 1'b1;
      pause_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ivl_q   <= ivl_d;
      hold_q  <= hold_d;
      start_q <= bus.start;
      pause_q <= bus.pause;
    end
  end

  assign bus.count   = count_q;
  assign bus.running = (state_q == RUN);
  assign bus.paused  = (state_q == PAUSE);
  assign bus.done    = (state_q == DONE);
  assign bus.tick    = tick_w;
endmodule

// File: tb/tb_countdown_ctrl.sv
// Randomized bench for countdown_ctrl against an
// elapsed-time reference model.
module tb_countdown_ctrl;
  localparam int OS = 4;
  localparam int DH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  countdown_if bus ();

  countdown_ctrl #(
    .ONE_SEC   (OS),
    .DONE_HOLD (DH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // model: 0 idle, 1 run, 2 pause, 3 done
  int m_mode;
  int m_load;
  int m_rc;
  int m_dc;
  bit m_ps;
  bit m_pp;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_load = 0;
    m_rc   = 0;
    m_dc   = 0;
    m_ps   = 1'b1;
    m_pp   = 1'b1;
  endtask

  task automatic model_step(input bit st, input bit pa,
                            input logic [15:0] sw);
    bit se, pe;
    se   = st & ~m_ps;
    pe   = pa & ~m_pp;
    m_ps = st;
    m_pp = pa;
    if (se) begin
      if (sw != 16'd0) begin
        m_mode = 1;
        m_load = int'(sw);
        m_rc   = 0;
      end else begin
        m_mode = 3;
        m_dc   = 0;
      end
    end else begin
      case (m_mode)
        1: begin
          m_rc++;
          if (m_rc == m_load * OS) begin
            m_mode = 3;
            m_dc   = 0;
          end else if (pe) begin
            m_mode = 2;
          end
        end
        2: if (pe) m_mode = 1;
        3: begin
          m_dc++;
          if (m_dc == DH * OS) m_mode = 0;
        end
        default: ;
      endcase
    end
  endtask

  function automatic int exp_count();
    if (m_mode == 1 || m_mode == 2)
      return m_load - m_rc / OS;
    return 0;
  endfunction

  function automatic bit exp_tick();
    if (m_mode == 1) return (m_rc % OS) == OS - 1;
    if (m_mode == 3) return (m_dc % OS) == OS - 1;
    return 1'b0;
  endfunction

  task automatic check_all();
    chk("count",   32'(bus.count),   32'(exp_count()));
    chk("running", 32'(bus.running), 32'(m_mode == 1));
    chk("paused",  32'(bus.paused),  32'(m_mode == 2));
    chk("done",    32'(bus.done),    32'(m_mode == 3));
    chk("tick",    32'(bus.tick),    32'(exp_tick()));
  endtask

  // called at a negedge; returns at the next negedge
  task automatic cyc(input bit st, input bit pa,
                     input logic [15:0] sw);
    bus.start  = st;
    bus.pause  = pa;
    bus.sw_val = sw;
    @(posedge clk);
    model_step(st, pa, sw);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit st,
                     input bit pa, input logic [15:0] sw);
    for (int i = 0; i < n; i++) cyc(st, pa, sw);
  endtask

  task automatic do_reset(input bit st);
    #2;
    bus.start = st;
    rst = 1'b1;
    #1;
    chk("rst_count",   32'(bus.count),   32'd0);
    chk("rst_running", 32'(bus.running), 32'd0);
    chk("rst_paused",  32'(bus.paused),  32'd0);
    chk("rst_done",    32'(bus.done),    32'd0);
    chk("rst_tick",    32'(bus.tick),    32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit st, pa;
    logic [15:0] sw;
    bus.start  = 1'b0;
    bus.pause  = 1'b0;
    bus.sw_val = 16'd0;
    model_reset();
    #1;
    chk("init_count", 32'(bus.count), 32'd0);
    chk("init_done",  32'(bus.done),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // basic run
    cyc(0, 0, 16'd3);
    cyc(1, 0, 16'd3);
    chk("basic_load", 32'(bus.count), 32'd3);
    run(12, 1, 0, 16'd7);
    chk("basic_done", 32'(bus.done), 32'd1);
    run(8, 0, 0, 16'd7);
    chk("basic_idle", 32'(bus.done), 32'd0);

    // pause / resume
    cyc(1, 0, 16'd5);
    run(5, 0, 0, 16'd5);
    cyc(0, 1, 16'd5);
    chk("pause_state", 32'(bus.paused), 32'd1);
    run(20, 0, 1, 16'd1);
    chk("pause_hold", 32'(bus.count), 32'd4);
    cyc(0, 0, 16'd1);
    cyc(0, 1, 16'd1);
    cyc(0, 1, 16'd1);
    cyc(0, 0, 16'd1);
    chk("resume_dec", 32'(bus.count), 32'd3);

    // restart
    cyc(1, 0, 16'd9);
    run(8, 0, 0, 16'd9);
    chk("restart_at7", 32'(bus.count), 32'd7);
    cyc(1, 0, 16'd2);
    chk("restart_load", 32'(bus.count), 32'd2);
    run(4, 0, 0, 16'd2);
    chk("restart_dec", 32'(bus.count), 32'd1);
    cyc(1, 1, 16'd4);
    chk("start_pause", 32'(bus.running), 32'd1);
    run(3, 0, 0, 16'd4);

    // zero load and restart from DONE
    cyc(1, 0, 16'd0);
    chk("zero_done", 32'(bus.done), 32'd1);
    run(8, 0, 0, 16'd0);
    chk("zero_idle", 32'(bus.done), 32'd0);
    cyc(1, 0, 16'd0);
    cyc(0, 0, 16'd0);
    cyc(1, 0, 16'd6);
    chk("done_restart", 32'(bus.count), 32'd6);

    // reset mid-run, start held across release
    cyc(0, 0, 16'd5);
    cyc(1, 0, 16'd5);
    do_reset(1'b1);
    run(6, 1, 0, 16'd5);
    chk("held_start", 32'(bus.running), 32'd0);
    cyc(0, 0, 16'd5);
    cyc(1, 0, 16'd5);
    chk("re_press", 32'(bus.count), 32'd5);

    // random phase
    st = 1'b1;
    pa = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) st = ~st;
      if ($urandom_range(0, 8) == 0) pa = ~pa;
      sw = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 599) == 0) begin
        do_reset(st);
      end else begin
        cyc(st, pa, sw);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
